pipeline_cpu_hz: RTL and testbench

//  Parametrised successor of the 5-stage (IF/ID/EX/MEM/WB) pipeline core. Adds internal PC,

---
 rtl/pipeline_cpu_hz.sv | 247 ++++++++++++++++++++++++
 tb/tb_pipeline_cpu_hz.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_cpu_hz.sv
// pipeline_cpu_hz -- five-stage (IF/ID/EX/MEM/WB) integer core.
//
// Internal PC, register file with write-through read, EX-stage operand
// forwarding, load-use / RAW hazard stalling and a retired-instruction
// counter. Instruction and data memories are external with combinational
// reads; the data memory writes on the clock edge while dm_we is high.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   instr_addr IF-stage PC towards instruction memory
//   instr      instruction word at instr_addr (same cycle)
//   dm_addr    MEM-stage address (EX/MEM ALU result)
//   dm_wdata   MEM-stage store data
//   dm_we      MEM-stage store strobe
//   dm_rdata   data memory read data at dm_addr (combinational)
//   wb_valid   a real (non-bubble) instruction is in WB
//   stall      PC and IF/ID are held this cycle
//   retire_cnt number of retired instructions, wraps at 2^32
module pipeline_cpu_hz #(
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = 32,
  parameter int              REG_AW   = 5,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter bit              FWD_EN   = 1'b1,
  parameter bit              R0_ZERO  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [31:0]       instr,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_valid,
  output logic              stall,
  output logic [31:0]       retire_cnt
);

  localparam int NREGS = 1 << REG_AW;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_SLL = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  // ---------------- pipeline state ----------------
  logic [PC_W-1:0]   pc_reg;
  logic [31:0]       ifid_instr;

  logic              idex_valid, idex_wr, idex_load, idex_store, idex_use_imm;
  logic [1:0]        idex_alu;
  logic [REG_AW-1:0] idex_dest, idex_rs, idex_rt;
  logic [DATA_W-1:0] idex_a, idex_b, idex_imm;
  logic [4:0]        idex_shamt;

  logic              exmem_valid, exmem_wr, exmem_load, exmem_store;
  logic [REG_AW-1:0] exmem_dest;
  logic [DATA_W-1:0] exmem_result, exmem_sdata;

  logic              memwb_valid, memwb_wr;
  logic [REG_AW-1:0] memwb_dest;
  logic [DATA_W-1:0] memwb_result;

  logic [DATA_W-1:0] rf [NREGS];

  // ---------------- ID: decode ----------------
  logic [5:0]        id_op, id_funct;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              id_valid, id_wr, id_load, id_store, id_use_imm, id_use_rt;
  logic [1:0]        id_alu;
  logic [REG_AW-1:0] id_dest;
  logic [DATA_W-1:0] id_rs_val, id_rt_val;

  assign id_op    = ifid_instr[31:26];
  assign id_funct = ifid_instr[5:0];
  assign id_rs    = ifid_instr[21 +: REG_AW];
  assign id_rt    = ifid_instr[16 +: REG_AW];
  assign id_rd    = ifid_instr[11 +: REG_AW];

  always_comb begin
    id_valid   = 1'b0;
    id_wr      = 1'b0;
    id_load    = 1'b0;
    id_store   = 1'b0;
    id_use_imm = 1'b0;
    id_use_rt  = 1'b0;
    id_alu     = ALU_ADD;
    id_dest    = id_rt;
    // the all-zero word would otherwise decode as sll r0,r0,0
    if (ifid_instr != 32'h0) begin
      case (id_op)
        6'h00: begin
          id_dest   = id_rd;
          id_use_rt = 1'b1;
          case (id_funct)
            6'h20:   begin id_valid = 1'b1; id_alu = ALU_ADD; end
            6'h22:   begin id_valid = 1'b1; id_alu = ALU_SUB; end
            6'h00:   begin id_valid = 1'b1; id_alu = ALU_SLL; end
            6'h25:   begin id_valid = 1'b1; id_alu = ALU_OR;  end
            default: id_valid = 1'b0;
          endcase
          id_wr = id_valid;
        end
        6'h08: begin id_valid = 1'b1; id_wr = 1'b1; id_use_imm = 1'b1; end
        6'h23: begin id_valid = 1'b1; id_wr = 1'b1; id_use_imm = 1'b1; id_load = 1'b1; end
        6'h2B: begin id_valid = 1'b1; id_use_imm = 1'b1; id_store = 1'b1; id_use_rt = 1'b1; end
        default: id_valid = 1'b0;
      endcase
    end
    // invalid words carry no sources; r0 is never a real destination
    if (!id_valid) id_use_rt = 1'b0;
    if (R0_ZERO && id_dest == '0) id_wr = 1'b0;
  end

  // Register read with write-through of the value being written in WB.
  always_comb begin
    id_rs_val = rf[id_rs];
    id_rt_val = rf[id_rt];
    if (memwb_wr && memwb_dest == id_rs) id_rs_val = memwb_result;
    if (memwb_wr && memwb_dest == id_rt) id_rt_val = memwb_result;
    if (R0_ZERO && id_rs == '0) id_rs_val = '0;
    if (R0_ZERO && id_rt == '0) id_rt_val = '0;
  end

  // ---------------- hazard detection ----------------
  logic hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt, load_use, raw_hazard;

  assign hit_ex_rs  = id_valid  && idex_wr  && idex_dest  == id_rs;
  assign hit_ex_rt  = id_use_rt && idex_wr  && idex_dest  == id_rt;
  assign hit_mem_rs = id_valid  && exmem_wr && exmem_dest == id_rs;
  assign hit_mem_rt = id_use_rt && exmem_wr && exmem_dest == id_rt;

  assign load_use   = idex_load && (hit_ex_rs || hit_ex_rt);
  // without forwarding, results are only visible once they reach WB
  assign raw_hazard = hit_ex_rs || hit_ex_rt || hit_mem_rs || hit_mem_rt;
  assign stall      = FWD_EN ? load_use : raw_hazard;

  // ---------------- EX: forwarding + ALU ----------------
  logic [DATA_W-1:0] ex_a, ex_rt, ex_b, ex_result;

  always_comb begin
    ex_a  = idex_a;
    ex_rt = idex_b;
    if (FWD_EN) begin
      // a load in EX/MEM is never forwarded: the load-use stall keeps
      // its consumer one slot further back, where MEM/WB supplies it
      if (exmem_wr && !exmem_load && exmem_dest == idex_rs) ex_a = exmem_result;
      else if (memwb_wr && memwb_dest == idex_rs)           ex_a = memwb_result;
      if (exmem_wr && !exmem_load && exmem_dest == idex_rt) ex_rt = exmem_result;
      else if (memwb_wr && memwb_dest == idex_rt)           ex_rt = memwb_result;
    end
    ex_b = idex_use_imm ? idex_imm : ex_rt;
    case (idex_alu)
      ALU_ADD: ex_result = ex_a + ex_b;
      ALU_SUB: ex_result = ex_a - ex_b;
      ALU_SLL: ex_result = ex_rt << idex_shamt;
      default: ex_result = ex_a | ex_b;
    endcase
  end

  // ---------------- outputs ----------------
  assign instr_addr = pc_reg;
  assign dm_addr    = exmem_result;
  assign dm_wdata   = exmem_sdata;
  assign dm_we      = exmem_store;
  assign wb_valid   = memwb_valid;

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= RESET_PC;
      ifid_instr   <= '0;
      idex_valid   <= 1'b0;
      idex_wr      <= 1'b0;
      idex_load    <= 1'b0;
      idex_store   <= 1'b0;
      idex_use_imm <= 1'b0;
      idex_alu     <= ALU_ADD;
      idex_dest    <= '0;
      idex_rs      <= '0;
      idex_rt      <= '0;
      idex_a       <= '0;
      idex_b       <= '0;
      idex_imm     <= '0;
      idex_shamt   <= '0;
      exmem_valid  <= 1'b0;
      exmem_wr     <= 1'b0;
      exmem_load   <= 1'b0;
      exmem_store  <= 1'b0;
      exmem_dest   <= '0;
      exmem_result <= '0;
      exmem_sdata  <= '0;
      memwb_valid  <= 1'b0;
      memwb_wr     <= 1'b0;
      memwb_dest   <= '0;
      memwb_result <= '0;
      retire_cnt   <= '0;
    end else begin
      if (!stall) begin
        pc_reg     <= pc_reg + PC_W'(4);
        ifid_instr <= instr;
      end

      // a stalled ID slot enters EX as a bubble
      idex_valid   <= id_valid && !stall;
      idex_wr      <= id_wr    && !stall;
      idex_load    <= id_load  && !stall;
      idex_store   <= id_store && !stall;
      idex_use_imm <= id_use_imm;
      idex_alu     <= id_alu;
      idex_dest    <= id_dest;
      idex_rs      <= id_rs;
      idex_rt      <= id_rt;
      idex_a       <= id_rs_val;
      idex_b       <= id_rt_val;
      idex_imm     <= DATA_W'(ifid_instr[15:0]);
      idex_shamt   <= ifid_instr[10:6];

      exmem_valid  <= idex_valid;
      exmem_wr     <= idex_wr;
      exmem_load   <= idex_load;
      exmem_store  <= idex_store;
      exmem_dest   <= idex_dest;
      exmem_result <= ex_result;
      exmem_sdata  <= ex_rt;

      memwb_valid  <= exmem_valid;
      memwb_wr     <= exmem_wr;
      memwb_dest   <= exmem_dest;
      memwb_result <= exmem_load ? dm_rdata : exmem_result;

      if (memwb_valid) retire_cnt <= retire_cnt + 32'd1;
    end
  end

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (memwb_wr) begin
      rf[memwb_dest] <= memwb_result;
    end
  end

endmodule

// File: tb/tb_pipeline_cpu_hz.sv
module tb_pipeline_cpu_hz;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // shared program, separate data memories for the two variants
  logic [31:0] imem   [64];
  logic [31:0] dmem_f [64];
  logic [31:0] dmem_n [64];
  logic [31:0] dinit  [64];

  logic [31:0] instr_addr_f, instr_f, dm_addr_f, dm_wdata_f, dm_rdata_f, retire_f;
  logic        dm_we_f, wb_valid_f, stall_f;
  logic [31:0] instr_addr_n, instr_n, dm_addr_n, dm_wdata_n, dm_rdata_n, retire_n;
  logic        dm_we_n, wb_valid_n, stall_n;

  assign instr_f    = (instr_addr_f < 32'd256) ? imem[instr_addr_f[7:2]] : 32'h0;
  assign instr_n    = (instr_addr_n < 32'd256) ? imem[instr_addr_n[7:2]] : 32'h0;
  assign dm_rdata_f = (dm_addr_f < 32'd256) ? dmem_f[dm_addr_f[7:2]] : 32'h0;
  assign dm_rdata_n = (dm_addr_n < 32'd256) ? dmem_n[dm_addr_n[7:2]] : 32'h0;

  pipeline_cpu_hz #(.FWD_EN(1'b1)) u_fwd (
    .clk(clk), .rst_n(rst_n), .instr_addr(instr_addr_f), .instr(instr_f),
    .dm_addr(dm_addr_f), .dm_wdata(dm_wdata_f), .dm_we(dm_we_f), .dm_rdata(dm_rdata_f),
    .wb_valid(wb_valid_f), .stall(stall_f), .retire_cnt(retire_f)
  );

  pipeline_cpu_hz #(.FWD_EN(1'b0)) u_nofwd (
    .clk(clk), .rst_n(rst_n), .instr_addr(instr_addr_n), .instr(instr_n),
    .dm_addr(dm_addr_n), .dm_wdata(dm_wdata_n), .dm_we(dm_we_n), .dm_rdata(dm_rdata_n),
    .wb_valid(wb_valid_n), .stall(stall_n), .retire_cnt(retire_n)
  );

  int checks = 0;
  int errors = 0;

  // observed
  logic [63:0] st_f[$], st_n[$];
  int stall_cnt_f, stall_cnt_n, wbv_f, wbv_n;
  // expected
  logic [63:0] exp_st[$];
  int exp_ret, exp_stall_f, exp_stall_n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int fn, input int rs, input int rt, input int rd, input int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic clear_prog();
    for (int k = 0; k < 64; k++) imem[k] = 32'h0;
  endtask

  // Architectural model: executes the program in order, records stores,
  // and derives each instruction's ID-exit cycle from the hazard rules.
  task automatic model_run(input int len);
    logic [31:0] r [32];
    logic [31:0] mem [64];
    int tf [64];
    int tn [64];
    int dst [64];
    bit ld [64];
    logic [31:0] w, a, b, res, addr;
    int op, rs, rt, rd, sh, fn, d;
    bit valid, use_rt, is_ld;
    for (int k = 0; k < 32; k++) r[k] = 32'h0;
    for (int k = 0; k < 64; k++) mem[k] = dinit[k];
    exp_st.delete();
    exp_ret = 0;
    for (int i = 0; i < len; i++) begin
      w  = imem[i];
      op = int'(w[31:26]); rs = int'(w[25:21]); rt = int'(w[20:16]);
      rd = int'(w[15:11]); sh = int'(w[10:6]);  fn = int'(w[5:0]);
      a  = (rs == 0) ? 32'h0 : r[rs];
      b  = (rt == 0) ? 32'h0 : r[rt];
      valid = 1'b0; use_rt = 1'b0; is_ld = 1'b0; d = -1; res = 32'h0;
      addr = a + {16'h0, w[15:0]};
      if (w != 32'h0) begin
        case (op)
          0: begin
            valid = 1'b1;
            case (fn)
              'h20: res = a + b;
              'h22: res = a - b;
              'h00: res = b << sh;
              'h25: res = a | b;
              default: valid = 1'b0;
            endcase
            if (valid) begin d = rd; use_rt = 1'b1; end
          end
          'h08: begin valid = 1'b1; d = rt; res = addr; end
          'h23: begin
            valid = 1'b1; is_ld = 1'b1; d = rt;
            res = (addr < 32'd256) ? mem[addr[7:2]] : 32'h0;
          end
          'h2B: begin
            valid = 1'b1; use_rt = 1'b1;
            exp_st.push_back({addr, b});
            if (addr < 32'd256) mem[addr[7:2]] = b;
          end
          default: valid = 1'b0;
        endcase
      end
      if (d == 0) d = -1;
      if (d > 0) r[d] = res;
      dst[i] = d;
      ld[i]  = is_ld;
      if (valid) exp_ret++;
      tf[i] = (i == 0) ? 0 : tf[i-1] + 1;
      tn[i] = tf[i];
      if (i > 0) tn[i] = tn[i-1] + 1;
      if (valid) begin
        if (i > 0 && ld[i-1] && dst[i-1] >= 0 &&
            (dst[i-1] == rs || (use_rt && dst[i-1] == rt)))
          tf[i] = tf[i-1] + 2;
        for (int j = 0; j < i; j++)
          if (dst[j] >= 0 && (dst[j] == rs || (use_rt && dst[j] == rt)) && tn[j] + 3 > tn[i])
            tn[i] = tn[j] + 3;
      end
    end
    exp_stall_f = tf[len-1] - (len - 1);
    exp_stall_n = tn[len-1] - (len - 1);
  endtask

  task automatic sample();
    if (dm_we_f) begin
      st_f.push_back({dm_addr_f, dm_wdata_f});
      if (dm_addr_f < 32'd256) dmem_f[dm_addr_f[7:2]] = dm_wdata_f;
    end
    if (dm_we_n) begin
      st_n.push_back({dm_addr_n, dm_wdata_n});
      if (dm_addr_n < 32'd256) dmem_n[dm_addr_n[7:2]] = dm_wdata_n;
    end
    if (stall_f)    stall_cnt_f++;
    if (stall_n)    stall_cnt_n++;
    if (wb_valid_f) wbv_f++;
    if (wb_valid_n) wbv_n++;
  endtask

  task automatic init_dmem();
    logic [31:0] v;
    for (int k = 0; k < 64; k++) begin
      v = (k == 0) ? 32'h1234 : $urandom;
      dinit[k] = v; dmem_f[k] = v; dmem_n[k] = v;
    end
  endtask

  task automatic start_run();
    st_f.delete(); st_n.delete();
    stall_cnt_f = 0; stall_cnt_n = 0; wbv_f = 0; wbv_n = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_prog(input string name, input int len);
    model_run(len);
    start_run();
    repeat (3 * len + 20) begin
      @(negedge clk);
      sample();
    end
    check({name, " stores F"}, 64'(st_f.size()), 64'(exp_st.size()));
    check({name, " stores N"}, 64'(st_n.size()), 64'(exp_st.size()));
    for (int i = 0; i < exp_st.size(); i++) begin
      if (i < st_f.size()) check($sformatf("%s st%0d F", name, i), st_f[i], exp_st[i]);
      if (i < st_n.size()) check($sformatf("%s st%0d N", name, i), st_n[i], exp_st[i]);
    end
    check({name, " stalls F"}, 64'(stall_cnt_f), 64'(exp_stall_f));
    check({name, " stalls N"}, 64'(stall_cnt_n), 64'(exp_stall_n));
    check({name, " retire F"}, 64'(retire_f), 64'(exp_ret));
    check({name, " retire N"}, 64'(retire_n), 64'(exp_ret));
    check({name, " wbvalid F"}, 64'(wbv_f), 64'(exp_ret));
    $display("prog %s: len=%0d stores=%0d retired=%0d stalls F=%0d N=%0d",
             name, len, st_f.size(), retire_f, stall_cnt_f, stall_cnt_n);
  endtask

  task automatic add_probes(input int base);
    for (int k = 1; k < 8; k++) imem[base + k - 1] = enc_i('h2B, 0, k, 'hE0 + 4 * (k - 1));
  endtask

  task automatic gen_random(input int n);
    int k, rs, rt, rd;
    clear_prog();
    for (int i = 0; i < n; i++) begin
      k  = int'($urandom_range(0, 9));
      rs = int'($urandom_range(0, 7));
      rt = int'($urandom_range(0, 7));
      rd = int'($urandom_range(0, 7));
      case (k)
        0: imem[i] = enc_r('h20, rs, rt, rd, 0);
        1: imem[i] = enc_r('h22, rs, rt, rd, 0);
        2: imem[i] = enc_r('h00, rs, rt, rd, int'($urandom_range(0, 31)));
        3: imem[i] = enc_r('h25, rs, rt, rd, 0);
        4: imem[i] = enc_i('h08, rs, rt, int'($urandom_range(0, 65535)));
        5: imem[i] = enc_i('h23, 0, rt, 4 * int'($urandom_range(0, 55)));
        6: imem[i] = enc_i('h2B, 0, rt, 4 * int'($urandom_range(0, 55)));
        7: imem[i] = 32'h0;
        8: imem[i] = enc_i('h3F, rs, rt, 'h1111);
        default: imem[i] = enc_r('h21, rs, rt, rd, 0);
      endcase
    end
    add_probes(n);
  endtask

  initial begin
    clear_prog();
    init_dmem();
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset instr_addr F", 64'(instr_addr_f), 64'h0);
    check("reset instr_addr N", 64'(instr_addr_n), 64'h0);
    check("reset dm_addr", 64'(dm_addr_f), 64'h0);
    check("reset dm_wdata", 64'(dm_wdata_f), 64'h0);
    check("reset dm_we", 64'(dm_we_f), 64'h0);
    check("reset wb_valid", 64'(wb_valid_f), 64'h0);
    check("reset stall", 64'(stall_f), 64'h0);
    check("reset retire_cnt", 64'(retire_f), 64'h0);

    // back-to-back ALU dependences
    clear_prog(); init_dmem();
    imem[0] = enc_i('h08, 0, 1, 5);
    imem[1] = enc_i('h08, 0, 2, 3);
    imem[2] = enc_r('h20, 1, 2, 3, 0);
    imem[3] = enc_i('h2B, 0, 3, 'h40);
    run_prog("alu_chain", 4);

    // load-use
    clear_prog(); init_dmem();
    imem[0] = enc_i('h23, 0, 4, 0);
    imem[1] = enc_r('h20, 4, 4, 5, 0);
    imem[2] = enc_i('h2B, 0, 5, 'h44);
    run_prog("load_use", 3);

    // store-data forwarding
    clear_prog(); init_dmem();
    imem[0] = enc_i('h08, 0, 1, 5);
    imem[1] = enc_i('h08, 0, 2, 3);
    imem[2] = enc_r('h22, 1, 2, 6, 0);
    imem[3] = enc_i('h2B, 0, 6, 8);
    run_prog("store_fwd", 4);

    // r0 writes ignored, shift
    clear_prog(); init_dmem();
    imem[0] = enc_i('h08, 0, 1, 5);
    imem[1] = enc_i('h08, 0, 0, 7);
    imem[2] = enc_r('h25, 0, 0, 7, 0);
    imem[3] = enc_r('h00, 0, 1, 8, 4);
    imem[4] = enc_i('h2B, 0, 7, 'h48);
    imem[5] = enc_i('h2B, 0, 8, 'h4C);
    run_prog("r0_sll", 6);

    for (int p = 0; p < 6; p++) begin
      gen_random(24);
      init_dmem();
      run_prog($sformatf("rand%0d", p), 31);
    end

    // reset with a store in MEM and loads/stores still in flight
    clear_prog(); init_dmem();
    imem[0] = enc_i('h08, 0, 1, 9);
    imem[1] = enc_i('h08, 0, 2, 'h33);
    imem[2] = enc_i('h23, 0, 3, 0);
    imem[3] = enc_i('h2B, 0, 2, 4);
    imem[4] = enc_i('h2B, 0, 1, 8);
    imem[5] = enc_r('h20, 3, 1, 4, 0);
    start_run();
    repeat (6) begin
      @(negedge clk);
      sample();
    end
    check("midreset store in MEM", 64'(dm_we_f), 64'h1);
    rst_n = 1'b0;
    #1;
    check("midreset dm_we F", 64'(dm_we_f), 64'h0);
    check("midreset dm_we N", 64'(dm_we_n), 64'h0);
    check("midreset instr_addr F", 64'(instr_addr_f), 64'h0);
    check("midreset instr_addr N", 64'(instr_addr_n), 64'h0);
    check("midreset wb_valid", 64'(wb_valid_f), 64'h0);
    check("midreset retire_cnt", 64'(retire_f), 64'h0);
    // register file must now be all zero: dump it through stores
    clear_prog(); init_dmem();
    add_probes(0);
    run_prog("rf_after_reset", 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
